// File: rtl/regfile_writeback_if.sv
// Writeback bundle: ALU result, load result, register-file write port and,
// when WB_HAZARD_EN is defined, the decode hazard probe (hzRs/hzBusy).
interface regfile_writeback_if;
    logic        aluValid;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        aluStall;
    logic        memValid;
    logic [4:0]  memRd;
    logic [31:0] memData;
    logic        memReady;
    logic        writeEnable;
    logic [4:0]  rd;
    logic [31:0] data;
`ifdef WB_HAZARD_EN
    logic [4:0]  hzRs;
    logic        hzBusy;
`endif

    modport master (
        output aluValid, aluRd, aluData, memValid, memRd, memData,
`ifdef WB_HAZARD_EN
        output hzRs,
        input  hzBusy,
`endif
        input  aluStall, memReady, writeEnable, rd, data
    );

    modport slave (
        input  aluValid, aluRd, aluData, memValid, memRd, memData,
`ifdef WB_HAZARD_EN
        input  hzRs,
        output hzBusy,
`endif
        output aluStall, memReady, writeEnable, rd, data
    );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write-port arbiter: ALU results win, loads queue in a FIFO and
// a starvation counter forces a pop. Optional hazard probe under WB_HAZARD_EN.
module regfile_writeback #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input logic                clk,
    input logic                reset,
    regfile_writeback_if.slave wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] STARVE_ONE = CNT_W'(1);

    logic [4:0]       fifo_rd_q   [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      data_q, data_d;

    logic empty, full, stall, ready, push, pop, alu_win;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == FULL_CNT);
        stall   = !reset && !empty && (cnt_q == STARVE_MAX);
        ready   = !reset && !full;
        // Loads to x0 are accepted but never enqueued.
        push    = wb.memValid && ready && (wb.memRd != 5'd0);
        alu_win = wb.aluValid && (wb.aluRd != 5'd0) && !stall;
        pop     = !alu_win && !empty;

        we_d   = alu_win || pop;
        rd_d   = rd_q;
        data_d = data_q;
        if (alu_win) begin
            rd_d   = wb.aluRd;
            data_d = wb.aluData;
        end else if (pop) begin
            rd_d   = fifo_rd_q[rptr_q];
            data_d = fifo_data_q[rptr_q];
        end

        wptr_d  = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d  = pop  ? rptr_q + PTR_ONE : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + COUNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - COUNT_ONE;
        end

        cnt_d = cnt_q;
        if (empty || pop) begin
            cnt_d = '0;
        end else if (alu_win && (cnt_q != STARVE_MAX)) begin
            cnt_d = cnt_q + STARVE_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            cnt_q   <= '0;
        end else begin
            we_q    <= we_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
        end
    end

    // FIFO payload needs no reset; validity comes from count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wptr_q]   <= wb.memRd;
            fifo_data_q[wptr_q] <= wb.memData;
        end
    end

    assign wb.aluStall    = stall;
    assign wb.memReady    = ready;
    assign wb.writeEnable = we_q;
    assign wb.rd          = rd_q;
    assign wb.data        = data_q;

`ifdef WB_HAZARD_EN
    logic             hz_hit;
    logic [PTR_W-1:0] hz_off;

    always_comb begin
        hz_hit = 1'b0;
        hz_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hz_off = PTR_W'(i) - rptr_q;
            if (({1'b0, hz_off} < count_q) && (fifo_rd_q[i] == wb.hzRs)) begin
                hz_hit = 1'b1;
            end
        end
    end

    assign wb.hzBusy = (wb.hzRs != 5'd0) && (hz_hit || (we_q && (rd_q == wb.hzRs)));
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: a queue-based reference model checked
// every cycle, plus literal expectations at the interesting points.
`timescale 1ns/1ps
module tb_regfile_writeback;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 3;

    logic clk = 1'b0;
    logic reset;

    regfile_writeback_if bus();

    regfile_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk  (clk),
        .reset(reset),
        .wb   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending loads and a plain starvation count.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         q_m[$];
    int          cnt_m  = 0;
    logic        m_we   = 1'b0;
    logic [4:0]  m_rd   = '0;
    logic [31:0] m_data = '0;

    function automatic logic m_stall();
        return (cnt_m == STARVE_LIMIT) && (q_m.size() != 0);
    endfunction

    initial begin : model_cmp
        bit  win, popped, had, rdy;
        wr_t w;
        forever begin
            @(posedge clk);
            if (reset) begin
                q_m.delete();
                cnt_m  = 0;
                m_we   = 1'b0;
                m_rd   = '0;
                m_data = '0;
            end else begin
                had    = (q_m.size() != 0);
                rdy    = (q_m.size() < DEPTH);
                win    = bus.aluValid && (bus.aluRd != 0) && !m_stall();
                popped = !win && had;
                if (win) begin
                    m_we = 1'b1; m_rd = bus.aluRd; m_data = bus.aluData;
                end else if (popped) begin
                    w = q_m.pop_front();
                    m_we = 1'b1; m_rd = w.rd; m_data = w.data;
                end else begin
                    m_we = 1'b0;
                end
                if (!had || popped) cnt_m = 0;
                else if (win && cnt_m < STARVE_LIMIT) cnt_m++;
                if (bus.memValid && rdy && bus.memRd != 0) begin
                    w.rd = bus.memRd; w.data = bus.memData;
                    q_m.push_back(w);
                end
            end
            @(negedge clk);
            chk("m_writeEnable", bus.writeEnable, m_we);
            chk("m_rd", bus.rd, m_rd);
            chk("m_data", bus.data, m_data);
            chk("m_aluStall", bus.aluStall, !reset && m_stall());
            chk("m_memReady", bus.memReady, !reset && (q_m.size() < DEPTH));
`ifdef WB_HAZARD_EN
            begin
                logic busy;
                busy = 1'b0;
                foreach (q_m[k]) if (q_m[k].rd == bus.hzRs) busy = 1'b1;
                if (m_we && m_rd == bus.hzRs) busy = 1'b1;
                chk("m_hzBusy", bus.hzBusy, (bus.hzRs != 0) && busy);
            end
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic alu(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.aluValid = v; bus.aluRd = r; bus.aluData = d;
    endtask

    task automatic mem(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.memValid = v; bus.memRd = r; bus.memData = d;
    endtask

    // Upstream ALU: a new result appears only after the current one was consumed.
    task automatic alu_cyc();
        logic s;
        s = bus.aluStall;
        cyc();
        if (!s) bus.aluData = bus.aluData + 32'd1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin : stim
        reset = 1'b1;
        alu(1, 9, 55);
        mem(1, 9, 66);
`ifdef WB_HAZARD_EN
        bus.hzRs = 5'd0;
`endif
        // Reset held over two edges with both sources active.
        cyc();
        at_neg();
        chk("rst_we", bus.writeEnable, 0);
        chk("rst_rd", bus.rd, 0);
        chk("rst_data", bus.data, 0);
        chk("rst_memReady", bus.memReady, 0);
        chk("rst_aluStall", bus.aluStall, 0);
        cyc();
        reset = 1'b0;
        mem(0, 0, 0);
        at_neg();
        chk("release_we", bus.writeEnable, 0);

        // ALU path and x0 drop.
        cyc();
        alu(1, 1, 123);
        at_neg();
        chk("first_we", bus.writeEnable, 1);
        chk("first_rd", bus.rd, 9);
        chk("first_data", bus.data, 55);
        cyc();
        alu(1, 0, 2121);
        at_neg();
        chk("alu_we", bus.writeEnable, 1);
        chk("alu_rd", bus.rd, 1);
        chk("alu_data", bus.data, 123);
        cyc();
        alu(0, 0, 0);
        at_neg();
        chk("x0_we", bus.writeEnable, 0);
        chk("x0_hold_rd", bus.rd, 1);
        chk("x0_hold_data", bus.data, 123);

        // Load latency with ALU idle.
        cyc();
        mem(1, 2, 321);
        cyc();
        mem(0, 0, 0);
        at_neg();
        chk("load_n1_we", bus.writeEnable, 0);
        cyc();
        at_neg();
        chk("load_we", bus.writeEnable, 1);
        chk("load_rd", bus.rd, 2);
        chk("load_data", bus.data, 321);
        cyc();
        at_neg();
        chk("load_after_we", bus.writeEnable, 0);

        // FIFO fill under continuous ALU traffic.
        cyc();
        alu(1, 10, 2000);
        mem(1, 3, 1003);
        for (int r = 4; r <= 7; r++) begin
            alu_cyc();
            if (r <= 6) mem(1, 5'(r), 32'(1000 + r));
            else        mem(0, 0, 0);
        end
        at_neg();
        chk("full_memReady", bus.memReady, 0);
        chk("full_aluStall", bus.aluStall, 1);
        chk("full_rd", bus.rd, 10);
        chk("full_data", bus.data, 2003);
        alu_cyc();
        at_neg();
        chk("drain3_rd", bus.rd, 3);
        chk("drain3_data", bus.data, 1003);
        chk("drain3_memReady", bus.memReady, 1);
        alu_cyc();
        bus.aluValid = 1'b0;
        at_neg();
        chk("held_alu_rd", bus.rd, 10);
        chk("held_alu_data", bus.data, 2004);
        for (int r = 4; r <= 6; r++) begin
            cyc();
            at_neg();
            chk("drain_we", bus.writeEnable, 1);
            chk("drain_rd", bus.rd, 5'(r));
            chk("drain_data", bus.data, 32'(1000 + r));
        end
        cyc();
        at_neg();
        chk("drained_we", bus.writeEnable, 0);

        // Starvation: one queued load behind a continuous ALU stream.
        cyc();
        alu(1, 11, 500);
        mem(1, 7, 77);
        alu_cyc();
        mem(0, 0, 0);
        alu_cyc();
        alu_cyc();
        at_neg();
        chk("starve_pre_stall", bus.aluStall, 0);
        alu_cyc();
        at_neg();
        chk("starve_stall", bus.aluStall, 1);
        chk("starve_alu_data", bus.data, 503);
        alu_cyc();
        at_neg();
        chk("starve_stall_once", bus.aluStall, 0);
        chk("starve_load_rd", bus.rd, 7);
        chk("starve_load_data", bus.data, 77);
        alu_cyc();
        bus.aluValid = 1'b0;
        at_neg();
        chk("starve_held_rd", bus.rd, 11);
        chk("starve_held_data", bus.data, 504);

`ifdef WB_HAZARD_EN
        cyc();
        bus.hzRs = 5'd5;
        mem(1, 5, 55);
        at_neg();
        chk("hz_idle", bus.hzBusy, 0);
        cyc();
        mem(0, 0, 0);
        at_neg();
        chk("hz_queued", bus.hzBusy, 1);
        cyc();
        at_neg();
        chk("hz_write_rd", bus.rd, 5);
        chk("hz_write", bus.hzBusy, 1);
        cyc();
        at_neg();
        chk("hz_after", bus.hzBusy, 0);
        cyc();
        bus.hzRs = 5'd0;
        mem(1, 5, 9);
        cyc();
        mem(0, 0, 0);
        at_neg();
        chk("hz_zero", bus.hzBusy, 0);
`endif

        cyc();
        cyc();
        at_neg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
